// File: rtl/sram_2p_arb.sv
// Two-requester round-robin arbiter in front of a dual-port SRAM: writes and reads are
// arbitrated independently, and read responses come back one cycle later tagged by requester.
module sram_2p_arb #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_ren,
  output logic [ADDR_W-1:0]     mem_raddr,
  input  logic [DATA_W-1:0]     mem_rdata
);

  logic [1:0] wr_req, rd_req;
  logic [1:0] wr_grant, rd_grant;
  logic       wr_ptr, rd_ptr;
  logic [1:0] vld_p1;

  // A lone request always wins; under contention the pointer names the winner.
  function automatic logic [1:0] arb(input logic [1:0] req, input logic ptr);
    logic [1:0] g;
    g = req;
    if (req == 2'b11) g = ptr ? 2'b10 : 2'b01;
    return g;
  endfunction

  assign wr_req = req_valid & req_we;
  assign rd_req = req_valid & ~req_we;

  // Stage p0: combinational grant and SRAM drive
  always_comb begin
    wr_grant  = arb(wr_req, wr_ptr);
    rd_grant  = arb(rd_req, rd_ptr);
    req_ready = wr_grant | rd_grant;
    mem_wen   = |wr_grant;
    mem_ren   = |rd_grant;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    if (wr_grant[0]) begin
      mem_waddr = req_addr[ADDR_W-1:0];
      mem_wdata = req_wdata[DATA_W-1:0];
    end else if (wr_grant[1]) begin
      mem_waddr = req_addr[2*ADDR_W-1:ADDR_W];
      mem_wdata = req_wdata[2*DATA_W-1:DATA_W];
    end
    if (rd_grant[0])      mem_raddr = req_addr[ADDR_W-1:0];
    else if (rd_grant[1]) mem_raddr = req_addr[2*ADDR_W-1:ADDR_W];
  end

  // Stage p1: pointer update and response valid, aligned with the SRAM read register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      vld_p1 <= 2'b00;
    end else begin
      if (wr_req == 2'b11) wr_ptr <= ~wr_ptr;
      if (rd_req == 2'b11) rd_ptr <= ~rd_ptr;
      vld_p1 <= rd_grant;
    end
  end

  assign resp_valid = vld_p1;
  assign resp_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_2p_arb.sv
// Bench for sram_2p_arb: directed scenarios plus randomized traffic, checked against a
// transaction-level model of arbitration priority and memory contents.
module tb_sram_2p_arb;
  localparam int AW = 6;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, req_we, resp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   resp_rdata, mem_wdata, mem_rdata;
  logic            mem_wen, mem_ren;
  logic [AW-1:0]   mem_waddr, mem_raddr;

  sram_2p_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Dual-port SRAM with write-through on a same-address read/write collision.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always_ff @(posedge clk) begin
    if (mem_wen) sram[mem_waddr] <= mem_wdata;
    if (mem_ren) mem_rdata <= (mem_wen && mem_waddr == mem_raddr) ? mem_wdata : sram[mem_raddr];
  end

  int vectors = 0;
  int errors  = 0;

  // Reference state: who has priority on each port, memory image, pending response.
  int            wr_pri, rd_pri;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [1:0]    exp_rv;
  logic [DW-1:0] exp_rd;
  logic [1:0]    exp_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [1:0] req, input int pri);
    if (req == 2'b00) return -1;
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    return pri;
  endfunction

  // Apply one command cycle (called just after a rising edge), check, then advance the model.
  task automatic cycle(input logic [1:0] v, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int ww, rw;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] data [2];
    logic [1:0] rg;
    addr[0] = a0; addr[1] = a1; data[0] = d0; data[1] = d1;
    req_valid = v; req_we = we; req_addr = {a1, a0}; req_wdata = {d1, d0};
    ww = winner(v & we, wr_pri);
    rw = winner(v & ~we, rd_pri);
    exp_ready = 2'b00;
    if (ww >= 0) exp_ready[ww] = 1'b1;
    if (rw >= 0) exp_ready[rw] = 1'b1;
    @(negedge clk);
    check("req_ready", req_ready, exp_ready);
    check("mem_wen", mem_wen, ww >= 0);
    check("mem_waddr", mem_waddr, ww >= 0 ? addr[ww] : 0);
    check("mem_wdata", mem_wdata, ww >= 0 ? data[ww] : 0);
    check("mem_ren", mem_ren, rw >= 0);
    check("mem_raddr", mem_raddr, rw >= 0 ? addr[rw] : 0);
    check("resp_valid", resp_valid, exp_rv);
    if (exp_rv != 2'b00) check("resp_rdata", resp_rdata, exp_rd);
    @(posedge clk);
    #1;
    if (ww >= 0) ref_mem[addr[ww]] = data[ww];
    rg = 2'b00;
    if (rw >= 0) begin
      rg[rw] = 1'b1;
      exp_rd = ref_mem[addr[rw]];
    end
    exp_rv = rg;
    if ((v & we) == 2'b11) wr_pri = 1 - ww;
    if ((v & ~we) == 2'b11) rd_pri = 1 - rw;
  endtask

  task automatic idle();
    cycle(2'b00, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    logic [1:0]    cv, cwe;
    logic [AW-1:0] ca [2];
    logic [DW-1:0] cd [2];
    rst = 1'b1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    wr_pri = 0; rd_pri = 0; exp_rv = 0; exp_rd = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i] = 0;
      ref_mem[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_ready", req_ready, 2'b00);
    check("rst_mem_en", {mem_wen, mem_ren}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset in the middle of a read: response must vanish at once
    cycle(2'b01, 2'b00, 9, 0, 0, 0);
    check("pre_rst_resp_valid", resp_valid, 2'b01);
    rst = 1'b1;
    #1;
    check("async_rst_resp_valid", resp_valid, 2'b00);
    exp_rv = 0; wr_pri = 0; rd_pri = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // Solo write then read of address 5
    cycle(2'b01, 2'b01, 5, 0, 32'hDEADBEEF, 0);
    cycle(2'b01, 2'b00, 5, 0, 0, 0);
    idle();

    // Read contention for four cycles
    repeat (4) cycle(2'b11, 2'b00, 1, 2, 0, 0);
    idle();

    // Write contention on address 3, loser holds until granted, then read back
    cycle(2'b11, 2'b11, 3, 3, 32'h11, 32'h22);
    check("wr_cont_first_A", exp_ready, 2'b01);
    cycle(2'b10, 2'b10, 3, 3, 32'h11, 32'h22);
    cycle(2'b01, 2'b00, 3, 0, 0, 0);
    idle();
    check("wr_cont_final", ref_mem[3], 32'h22);

    // Concurrent write by A and read by B on address 7
    cycle(2'b11, 2'b01, 7, 7, 32'h55, 0);
    idle();

    // Pointer unaffected by uncontended reads
    repeat (3) cycle(2'b01, 2'b00, 4, 0, 0, 0);
    cycle(2'b11, 2'b00, 4, 6, 0, 0);
    cycle(2'b11, 2'b00, 4, 6, 0, 0);
    idle();

    // Randomized traffic; each requester holds its command until accepted
    cv = 0; cwe = 0;
    for (int r = 0; r < 2; r++) begin
      ca[r] = 0;
      cd[r] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!cv[r]) begin
          cv[r]  = ($urandom_range(0, 3) != 0);
          cwe[r] = $urandom_range(0, 1);
          ca[r]  = AW'($urandom_range(0, 7));
          cd[r]  = $urandom;
        end
      end
      cycle(cv, cwe, ca[0], ca[1], cd[0], cd[1]);
      cv = cv & ~exp_ready;
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
